// File: rtl/clip_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : clip_ctrl_pkg
// Brief    : Shared state encoding and defaults for the clip record/play sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package clip_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_RECORD = 3'b010,
    ST_PLAY   = 3'b100
  } state_t;

  // 2 s of audio at 8 kHz
  localparam int C_CLIP_SAMPLES_DEFAULT = 16000;

endpackage

`default_nettype wire

// File: rtl/clip_addr_counter.sv
//------------------------------------------------------------------------------
// Module   : clip_addr_counter
// Brief    : Tick-enabled clip address counter with terminal compare and wrap.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clip_addr_counter #(
  parameter int ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_tick,
  input  logic [ADDR_W-1:0] i_limit,
  input  logic              i_wrap,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_term
);

  logic [ADDR_W-1:0] r_addr;
  logic              w_at_limit;

  assign w_at_limit = (r_addr == i_limit);
  assign o_term     = i_tick && w_at_limit;
  assign o_addr     = r_addr;

  // Without wrap the count parks on the limit, so it can never run past it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= '0;
    end else if (i_clear) begin
      r_addr <= '0;
    end else if (i_tick) begin
      if (!w_at_limit) begin
        r_addr <= r_addr + ADDR_W'(1);
      end else if (i_wrap) begin
        r_addr <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_clip_controller.sv
//------------------------------------------------------------------------------
// Module   : multi_clip_controller
// Brief    : Record/playback sequencer driving NUM_CLIPS clip memories.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multi_clip_controller
  import clip_ctrl_pkg::*;
#(
  parameter int NUM_CLIPS    = 2,
  parameter int CLIP_SAMPLES = C_CLIP_SAMPLES_DEFAULT,
  parameter int ADDR_W       = $clog2(CLIP_SAMPLES),
  parameter int SEL_W        = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 record_req,
  input  logic                 play_req,
  input  logic                 stop_req,
  input  logic                 loop_en,
  input  logic [SEL_W-1:0]     clip_sel,
  input  logic                 sample_tick,
  output logic [NUM_CLIPS-1:0] mem_en,
  output logic [NUM_CLIPS-1:0] mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [NUM_CLIPS-1:0] clip_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int                LEN_W       = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(CLIP_SAMPLES - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [SEL_W-1:0]     r_sel_q;
  logic [LEN_W-1:0]     r_len [NUM_CLIPS];
  logic [NUM_CLIPS-1:0] r_clip_valid;
  logic                 r_done;
  logic                 r_error;

  logic                 w_req_in_range;
  logic                 w_req_recorded;
  logic                 w_start_rec;
  logic                 w_start_play;
  logic                 w_reject;
  logic                 w_finish;
  logic                 w_rec_end;
  logic                 w_busy;
  logic [NUM_CLIPS-1:0] w_sel_onehot;
  logic [LEN_W-1:0]     w_len_sel;
  logic [LEN_W-1:0]     w_len_new;
  logic [ADDR_W-1:0]    w_limit;
  logic [ADDR_W-1:0]    w_addr;
  logic                 w_wrap;
  logic                 w_term;
  logic                 w_clear;

  // Decoded lookups avoid indexing past NUM_CLIPS when clip_sel is out of range.
  always_comb begin
    w_req_in_range = 1'b0;
    w_req_recorded = 1'b0;
    for (int i = 0; i < NUM_CLIPS; i++) begin
      if (clip_sel == SEL_W'(i)) begin
        w_req_in_range = 1'b1;
        w_req_recorded = r_clip_valid[i];
      end
    end
  end

  always_comb begin
    w_len_sel = '0;
    for (int i = 0; i < NUM_CLIPS; i++) begin
      if (r_sel_q == SEL_W'(i)) begin
        w_len_sel = r_len[i];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CLIPS; gi++) begin : g_decode
    assign w_sel_onehot[gi] = (r_sel_q == SEL_W'(gi));
  end

  assign w_clear   = (r_state == ST_IDLE);
  assign w_wrap    = (r_state == ST_PLAY) && loop_en;
  assign w_limit   = (r_state == ST_PLAY) ? ADDR_W'(w_len_sel - LEN_W'(1)) : C_LAST_ADDR;
  // A tick in the ending cycle is a sample already written, so it counts.
  assign w_len_new = LEN_W'(w_addr) + LEN_W'(sample_tick);

  clip_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clear (w_clear),
    .i_tick  (sample_tick),
    .i_limit (w_limit),
    .i_wrap  (w_wrap),
    .o_addr  (w_addr),
    .o_term  (w_term)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start_rec  = 1'b0;
    w_start_play = 1'b0;
    w_reject     = 1'b0;
    w_finish     = 1'b0;
    w_rec_end    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (record_req) begin
          if (w_req_in_range) begin
            w_start_rec  = 1'b1;
            w_next_state = ST_RECORD;
          end else begin
            w_reject = 1'b1;
          end
        end else if (play_req) begin
          if (w_req_in_range && w_req_recorded) begin
            w_start_play = 1'b1;
            w_next_state = ST_PLAY;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_RECORD: begin
        if (stop_req || w_term) begin
          w_rec_end    = 1'b1;
          w_finish     = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (stop_req || (w_term && !loop_en)) begin
          w_finish     = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_q      <= '0;
      r_clip_valid <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      for (int i = 0; i < NUM_CLIPS; i++) begin
        r_len[i] <= '0;
      end
    end else begin
      r_done  <= w_finish;
      r_error <= w_reject;
      if (w_start_rec || w_start_play) begin
        r_sel_q <= clip_sel;
      end
      for (int i = 0; i < NUM_CLIPS; i++) begin
        // Invalidate up front so an aborted recording never reads back as valid.
        if (w_start_rec && (clip_sel == SEL_W'(i))) begin
          r_clip_valid[i] <= 1'b0;
        end
        if (w_rec_end && (r_sel_q == SEL_W'(i))) begin
          r_len[i]        <= w_len_new;
          r_clip_valid[i] <= (w_len_new != '0);
        end
      end
    end
  end

  assign w_busy     = (r_state == ST_RECORD) || (r_state == ST_PLAY);
  assign busy       = w_busy;
  assign mem_en     = w_busy ? w_sel_onehot : '0;
  assign mem_we     = ((r_state == ST_RECORD) && sample_tick) ? w_sel_onehot : '0;
  assign mem_addr   = w_busy ? w_addr : '0;
  assign clip_valid = r_clip_valid;
  assign done       = r_done;
  assign error      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_multi_clip_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_multi_clip_controller
// Brief    : Scoreboard bench for multi_clip_controller (2-clip and 3-clip builds).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_multi_clip_controller;

  localparam logic [1:0] K_ACC  = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] en;
    logic [1:0] we;
    logic [2:0] addr;
    logic [1:0] cv;
  } ev_t;

  ev_t exp_q[$];
  ev_t m_got;
  ev_t m_exp;
  logic m_hit;
  int checks = 0;
  int errors = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic       record_req, play_req, stop_req, loop_en, sample_tick;
  logic [0:0] clip_sel;
  logic [1:0] mem_en, mem_we, clip_valid;
  logic [2:0] mem_addr;
  logic       busy, done, error;

  logic       rec_b, play_b, zero_b;
  logic [1:0] sel_b;
  logic [2:0] en_b, we_b, cv_b;
  logic [2:0] addr_b;
  logic       busy_b, done_b, error_b;

  multi_clip_controller #(.NUM_CLIPS(2), .CLIP_SAMPLES(8)) dut (
    .clock(clock), .reset_n(reset_n), .record_req(record_req), .play_req(play_req),
    .stop_req(stop_req), .loop_en(loop_en), .clip_sel(clip_sel), .sample_tick(sample_tick),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .clip_valid(clip_valid),
    .busy(busy), .done(done), .error(error)
  );

  multi_clip_controller #(.NUM_CLIPS(3), .CLIP_SAMPLES(8)) dut_b (
    .clock(clock), .reset_n(reset_n), .record_req(rec_b), .play_req(play_b),
    .stop_req(zero_b), .loop_en(zero_b), .clip_sel(sel_b), .sample_tick(zero_b),
    .mem_en(en_b), .mem_we(we_b), .mem_addr(addr_b), .clip_valid(cv_b),
    .busy(busy_b), .done(done_b), .error(error_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [1:0] en, input logic [1:0] we,
                      input logic [2:0] addr, input logic [1:0] cv);
    ev_t e;
    e.kind = k; e.en = en; e.we = we; e.addr = addr; e.cv = cv;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic tk, input logic rq, input logic pl, input logic sp,
                      input logic lp, input logic s);
    sample_tick = tk; record_req = rq; play_req = pl; stop_req = sp; loop_en = lp;
    clip_sel = s;
    @(posedge clock);
    #1;
  endtask

  // Monitor: every memory access on a tick, done pulse or error pulse is an event.
  always @(negedge clock) begin
    if (reset_n) begin
      m_hit = 1'b1;
      if (sample_tick && busy) m_got.kind = K_ACC;
      else if (done)           m_got.kind = K_DONE;
      else if (error)          m_got.kind = K_ERR;
      else                     m_hit = 1'b0;
      if (m_hit) begin
        m_got.en = mem_en; m_got.we = mem_we; m_got.addr = mem_addr; m_got.cv = clip_valid;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got %h required none", m_got);
        end else begin
          m_exp = exp_q.pop_front();
          if (m_got !== m_exp) begin
            errors++;
            $display("FAIL scoreboard_event: got %h required %h", m_got, m_exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    sample_tick = 0; record_req = 0; play_req = 0; stop_req = 0; loop_en = 0; clip_sel = 0;
    rec_b = 0; play_b = 0; zero_b = 0; sel_b = 0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_clip_valid", clip_valid, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0, 0);

    // Play of an unrecorded clip is rejected
    push(K_ERR, 2'b00, 2'b00, 3'd0, 2'b00);
    step(0, 0, 1, 0, 0, 1);
    check("rej_busy", busy, 0);
    check("rej_error", error, 1);
    step(0, 0, 0, 0, 0, 0);
    check("rej_error_pulse", error, 0);

    // Full-length record of clip 1, with one idle gap
    step(0, 1, 0, 0, 0, 1);
    check("rec1_busy", busy, 1);
    check("rec1_mem_en", mem_en, 2'b10);
    for (int i = 0; i < 8; i++) begin
      push(K_ACC, 2'b10, 2'b10, 3'(i), 2'b00);
      if (i == 7) push(K_DONE, 2'b00, 2'b00, 3'd0, 2'b10);
      step(1, 0, 0, 0, 0, 1);
      if (i == 2) begin
        step(0, 0, 0, 0, 0, 1);
        check("rec1_gap_addr", mem_addr, 3);
      end
    end
    check("rec1_done", done, 1);
    check("rec1_busy_off", busy, 0);
    check("rec1_valid", clip_valid, 2'b10);

    // Back-to-back: record and play together in the done cycle -> record clip 0
    step(0, 1, 1, 0, 0, 0);
    check("rec0_busy", busy, 1);
    check("rec0_mem_en", mem_en, 2'b01);
    push(K_ACC, 2'b01, 2'b01, 3'd0, 2'b10);
    step(1, 0, 1, 0, 0, 0);
    push(K_ACC, 2'b01, 2'b01, 3'd1, 2'b10);
    step(1, 0, 0, 0, 0, 0);
    push(K_ACC, 2'b01, 2'b01, 3'd2, 2'b10);
    push(K_DONE, 2'b00, 2'b00, 3'd0, 2'b11);
    step(1, 0, 0, 1, 0, 0);
    check("rec0_done", done, 1);
    check("rec0_valid", clip_valid, 2'b11);

    // Play clip 0 (length 3) without loop
    step(0, 0, 1, 0, 0, 0);
    check("play0_mem_en", mem_en, 2'b01);
    for (int i = 0; i < 3; i++) begin
      push(K_ACC, 2'b01, 2'b00, 3'(i), 2'b11);
      if (i == 2) push(K_DONE, 2'b00, 2'b00, 3'd0, 2'b11);
      step(1, 0, 0, 0, 0, 0);
    end
    check("play0_done", done, 1);
    check("play0_busy_off", busy, 0);
    step(0, 0, 0, 0, 0, 0);

    // Looped play of clip 0, then stop
    step(0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      push(K_ACC, 2'b01, 2'b00, 3'(i % 3), 2'b11);
      step(1, 0, 0, 0, 1, 0);
    end
    check("loop_busy", busy, 1);
    check("loop_no_done", done, 0);
    push(K_DONE, 2'b00, 2'b00, 3'd0, 2'b11);
    step(0, 0, 0, 1, 1, 0);
    check("loop_stop_busy", busy, 0);
    check("loop_stop_done", done, 1);
    step(0, 0, 0, 0, 0, 0);

    // Reset in the middle of recording clip 1
    step(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      push(K_ACC, 2'b10, 2'b10, 3'(i), 2'b01);
      step(1, 0, 0, 0, 0, 1);
    end
    sample_tick = 0;
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_mem_en", mem_en, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_clip_valid", clip_valid, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    push(K_ERR, 2'b00, 2'b00, 3'd0, 2'b00);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // Three-clip build: clip_sel 3 is out of range
    rec_b = 1; sel_b = 2'd3;
    @(posedge clock);
    #1 rec_b = 0;
    check("b_rec_error", error_b, 1);
    check("b_rec_busy", busy_b, 0);
    play_b = 1;
    @(posedge clock);
    #1 play_b = 0;
    check("b_play_error", error_b, 1);
    @(posedge clock);
    #1;
    check("b_error_clear", error_b, 0);

    step(0, 0, 0, 0, 0, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_clip_controller.md
# multi_clip_controller

Parametrised record/playback sequencer that owns NUM_CLIPS clip memories and drives their enable, write-enable and shared address. Replaces the fixed two-clip controller and its external 2-second timer: clip duration is counted internally in sample ticks. The block adds record-length capture, early stop, loop playback and rejection of unrecorded clips. It sits between the button/switch debounce logic and the clip RAMs.

## Interface
- NUM_CLIPS, 2: number of clip memories, ≥1
- CLIP_SAMPLES, 16000: maximum clip length in samples (2 s at 8 kHz), ≥2
- ADDR_W, $clog2(CLIP_SAMPLES): derived; memory address width
- SEL_W, max(1,$clog2(NUM_CLIPS)): derived; clip select width

- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- record_req  in  1  start recording clip_sel (level, sampled in IDLE only)
- play_req  in  1  start playing clip_sel (level, sampled in IDLE only)
- stop_req  in  1  end current record/play
- loop_en  in  1  playback wraps instead of finishing; sampled every tick
- clip_sel  in  SEL_W  target clip, sampled on request accept
- sample_tick  in  1  one-cycle strobe at sample rate; advances address
- mem_en  out  NUM_CLIPS  one-hot enable of the selected clip memory
- mem_we  out  NUM_CLIPS  one-hot write enable, asserted only on tick cycles
- mem_addr  out  ADDR_W  shared address to all clip memories
- clip_valid  out  NUM_CLIPS  bit i = clip i holds a recording
- busy  out  1  state is RECORD or PLAY
- done  out  1  one-cycle pulse, operation ended normally or by stop
- error  out  1  one-cycle pulse, request rejected

## Operation
- States: IDLE, RECORD, PLAY.
- IDLE → RECORD on record_req (record has priority over play_req when both are high); latch sel_q=clip_sel, addr=0, clear clip_valid[sel_q].
- IDLE → PLAY on play_req when clip_valid[clip_sel]=1; latch sel_q and addr=0.
- Rejected with an error pulse, staying in IDLE: clip_sel ≥ NUM_CLIPS on either request, or play_req with clip_valid[clip_sel]=0.
- Requests in RECORD/PLAY are ignored and not queued; stop_req in IDLE is ignored.
- RECORD: mem_en[sel_q]=1; mem_we[sel_q]=sample_tick. On a tick, the write lands at mem_addr, then addr increments.
- RECORD ends on a tick with addr=CLIP_SAMPLES-1, or on stop_req. Then len[sel_q] = samples written, counting a tick in the same cycle. clip_valid[sel_q] = (len≠0). Return to IDLE and pulse done.
- PLAY: mem_en[sel_q]=1, mem_we=0. Address advances per tick.
- PLAY at a tick with addr=len[sel_q]-1: if loop_en, addr→0 and stay in PLAY (no done). Otherwise go to IDLE and pulse done.
- stop_req in PLAY: go to IDLE and pulse done.
- stop_req coincident with a terminal tick: a single done; the length includes the tick.
- In IDLE: mem_en=0, mem_we=0, mem_addr=0.
- len[] is NUM_CLIPS×(ADDR_W+1) bits, width-safe for CLIP_SAMPLES. The addr counter never exceeds CLIP_SAMPLES-1.

## Timing
- Reset (async assert, sync release): state IDLE, addr 0, sel_q 0, len[] 0, clip_valid 0, done 0, error 0, busy 0, mem_en/mem_we 0.
- A request high at edge k puts the state in RECORD/PLAY after k. mem_en and busy are high in cycle k+1.
- mem_we is combinational from the registered state AND sample_tick.
- done and error are registered, high for exactly one cycle after the terminating/rejecting edge. busy drops in the same cycle done rises.
- A new request is accepted in the done cycle (back-to-back operations).
- Reset mid-operation aborts immediately. The partial clip is invalid because clip_valid was cleared at record start.

## Structure
- Package clip_ctrl_pkg holds the state typedef (one-hot enum IDLE/RECORD/PLAY) and a default CLIP_SAMPLES constant.
- One sub-module, clip_addr_counter: tick-enabled counter with sync clear, a terminal-compare input (limit) and a wrap input. Outputs addr and a terminal-hit strobe.
- Top level holds the FSM, sel_q, len[], clip_valid and one-hot decode.

## Test plan
- Full record: NUM_CLIPS=2, CLIP_SAMPLES=8, record clip 1, 8 ticks → mem_we[1] on each tick, addr 0..7, done pulse after tick 8, clip_valid=2'b10, len[1]=8.
- Early stop: record clip 0, stop_req with the 3rd tick → len[0]=3. Then play clip 0 without loop → addr 0,1,2, done after 3rd tick, mem_we stays 0.
- Loop: play clip 0 (len 3) with loop_en=1 for 7 ticks → addr 0,1,2,0,1,2,0, no done. Then stop_req → done, busy 0.
- Rejects: play_req on unrecorded clip 1 → error pulse, stays IDLE. NUM_CLIPS=3 with clip_sel=3 → error pulse.
- Simultaneous requests: record_req and play_req together → RECORD. play_req during RECORD → ignored. record_req in the done cycle → accepted.
- Reset mid-record: reset_n low after 4 ticks → all outputs 0 asynchronously, clip_valid 0. Subsequent play_req → error pulse.
